// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings plus the types and helpers used by the AHB-to-APB bridge.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;
  localparam logic [2:0] HSIZE_B128  = 3'b100;
  localparam logic [2:0] HSIZE_B256  = 3'b101;
  localparam logic [2:0] HSIZE_B512  = 3'b110;
  localparam logic [2:0] HSIZE_B1024 = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    ERR1,
    ERR2
  } apb_bridge_state_t;

  // Byte strobes for a transfer of 2^hsize bytes, base aligned down to the size.
  // Result is sized for the widest legal bus (128 bytes); callers keep the low 'bytes' bits.
  function automatic logic [127:0] gen_pstrb(input logic [2:0]  hsize,
                                             input logic [6:0]  haddr_lsbs,
                                             input int unsigned bytes);
    int unsigned size_bytes;
    int unsigned base;
    logic [127:0] strb;
    size_bytes = 32'd1 << hsize;
    base       = 32'(haddr_lsbs) & ~(size_bytes - 32'd1) & (bytes - 32'd1);
    strb       = '0;
    for (int unsigned i = 0; i < 128; i++) begin
      if (i >= base && i < base + size_bytes && i < bytes) strb[i] = 1'b1;
    end
    return strb;
  endfunction

endpackage

// File: rtl/ahb3lite_apb_bridge_if.sv
// Combined AHB3-Lite / APB4 signal bundle; 'slave' is the bridge view, 'master' the system view.
interface ahb3lite_apb_bridge_if #(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned PADDR_SIZE = 10
);

  logic                    HSEL;
  logic [HADDR_SIZE-1:0]   HADDR;
  logic [HDATA_SIZE-1:0]   HWDATA;
  logic [HDATA_SIZE-1:0]   HRDATA;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [3:0]              HPROT;
  logic [1:0]              HTRANS;
  logic                    HREADY;
  logic                    HREADYOUT;
  logic                    HRESP;

  logic                    PSEL;
  logic                    PENABLE;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic                    PWRITE;
  logic [HDATA_SIZE-1:0]   PWDATA;
  logic [HDATA_SIZE/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic [HDATA_SIZE-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HPROT, HTRANS, HREADY,
    output HRDATA, HREADYOUT, HRESP,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HPROT, HTRANS, HREADY,
    input  HRDATA, HREADYOUT, HRESP,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/ahb3lite_apb_bridge.sv
// AHB3-Lite slave to APB4 master bridge; every AHB transfer becomes one APB SETUP/ACCESS pair.
module ahb3lite_apb_bridge
  import ahb3lite_pkg::*;
#(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned PADDR_SIZE = 10
) (
    input logic                  PCLK,
    input logic                  PRESETn,
    ahb3lite_apb_bridge_if.slave bus
);

  localparam int unsigned BYTES    = HDATA_SIZE / 8;
  localparam int unsigned ADDR_LSB = $clog2(BYTES);

  apb_bridge_state_t state, state_nxt;

  logic                  accept;
  logic                  size_ok;
  logic                  latch_en;
  logic                  load_rdata;
  logic                  hreadyout;
  logic                  hresp;
  logic                  psel;
  logic                  penable;
  logic [6:0]            haddr_lsbs;
  logic [127:0]          pstrb_full;

  logic [PADDR_SIZE-1:0] paddr_q;
  logic                  pwrite_q;
  logic [BYTES-1:0]      pstrb_q;
  logic [2:0]            pprot_q;
  logic [HDATA_SIZE-1:0] hrdata_q;

  always_comb begin
    haddr_lsbs = '0;
    for (int unsigned i = 0; i < ADDR_LSB; i++) haddr_lsbs[i] = bus.HADDR[i];
  end

  always_comb begin
    pstrb_full = gen_pstrb(bus.HSIZE, haddr_lsbs, BYTES);
    accept     = bus.HSEL & bus.HREADY &
                 ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));
    size_ok    = (bus.HSIZE <= 3'(ADDR_LSB));
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    latch_en   = 1'b0;
    load_rdata = 1'b0;
    hreadyout  = 1'b1;
    hresp      = HRESP_OKAY;
    psel       = 1'b0;
    penable    = 1'b0;
    case (state)
      IDLE, RESP, ERR2: begin
        if (state == ERR2) hresp = HRESP_ERROR;
        if (accept) begin
          if (size_ok) begin
            state_nxt = SETUP;
            latch_en  = 1'b1;
          end else begin
            state_nxt = ERR1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP: begin
        psel      = 1'b1;
        hreadyout = 1'b0;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        hreadyout = 1'b0;
        if (bus.PREADY) begin
          if (bus.PSLVERR) begin
            state_nxt = ERR1;
          end else begin
            state_nxt  = RESP;
            load_rdata = ~pwrite_q;
          end
        end
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_nxt = ERR2;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // APB address/control registers only move on an accepted, well-sized transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      hrdata_q <= '0;
    end else begin
      if (latch_en) begin
        paddr_q  <= bus.HADDR[PADDR_SIZE-1:0];
        pwrite_q <= bus.HWRITE;
        pstrb_q  <= bus.HWRITE ? pstrb_full[BYTES-1:0] : '0;
        pprot_q  <= {~bus.HPROT[0], 1'b1, bus.HPROT[1]};
      end
      if (load_rdata) hrdata_q <= bus.PRDATA;
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.PPROT     = pprot_q;
  assign bus.PWDATA    = bus.HWDATA;

endmodule

// File: tb/tb_ahb3lite_apb_bridge.sv
// Directed self-checking bench for ahb3lite_apb_bridge with hand-computed expectations.
module tb_ahb3lite_apb_bridge;
  import ahb3lite_pkg::*;

  logic PCLK;
  logic PRESETn;
  int unsigned n_cmp;
  int unsigned n_bad;

  ahb3lite_apb_bridge_if #(.HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(10)) bus_if ();

  ahb3lite_apb_bridge #(
    .HADDR_SIZE(32),
    .HDATA_SIZE(32),
    .PADDR_SIZE(10)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus_if.slave)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [3:0] prot);
    bus_if.HSEL   = 1'b1;
    bus_if.HTRANS = HTRANS_NONSEQ;
    bus_if.HADDR  = addr;
    bus_if.HWRITE = wr;
    bus_if.HSIZE  = size;
    bus_if.HPROT  = prot;
  endtask

  task automatic bus_idle();
    bus_if.HSEL   = 1'b0;
    bus_if.HTRANS = HTRANS_IDLE;
  endtask

  // Full zero-wait write starting in IDLE; checks strobes in SETUP and completion in RESP.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] data, input logic [3:0] exp_strb);
    addr_phase(addr, 1'b1, size, 4'b0011);
    tick();
    bus_idle();
    bus_if.HWDATA = data;
    check_eq({tag, "_psel"},  64'(bus_if.PSEL),  64'd1);
    check_eq({tag, "_pstrb"}, 64'(bus_if.PSTRB), 64'(exp_strb));
    tick();
    check_eq({tag, "_pen"},   64'(bus_if.PENABLE), 64'd1);
    tick();
    check_eq({tag, "_done"},  64'(bus_if.HREADYOUT), 64'd1);
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    PRESETn        = 1'b0;
    bus_if.HSEL    = 1'b0;
    bus_if.HADDR   = '0;
    bus_if.HWDATA  = '0;
    bus_if.HWRITE  = 1'b0;
    bus_if.HSIZE   = HSIZE_WORD;
    bus_if.HPROT   = 4'b0000;
    bus_if.HTRANS  = HTRANS_IDLE;
    bus_if.HREADY  = 1'b1;
    bus_if.PRDATA  = '0;
    bus_if.PREADY  = 1'b1;
    bus_if.PSLVERR = 1'b0;

    #12;
    check_eq("rst_hreadyout", 64'(bus_if.HREADYOUT), 64'd1);
    check_eq("rst_hresp",     64'(bus_if.HRESP),     64'd0);
    check_eq("rst_hrdata",    64'(bus_if.HRDATA),    64'd0);
    check_eq("rst_psel",      64'(bus_if.PSEL),      64'd0);
    check_eq("rst_penable",   64'(bus_if.PENABLE),   64'd0);
    check_eq("rst_paddr_ctl", 64'({bus_if.PADDR, bus_if.PWRITE, bus_if.PSTRB, bus_if.PPROT}), 64'd0);
    PRESETn = 1'b1;
    tick();

    // Word write 0x104
    addr_phase(32'h104, 1'b1, HSIZE_WORD, 4'b0011);
    check_eq("w1_idle_ready", 64'(bus_if.HREADYOUT), 64'd1);
    tick();
    bus_idle();
    bus_if.HWDATA = 32'hDEADBEEF;
    #1;
    check_eq("w1_psel",    64'(bus_if.PSEL),      64'd1);
    check_eq("w1_penable", 64'(bus_if.PENABLE),   64'd0);
    check_eq("w1_paddr",   64'(bus_if.PADDR),     64'h104);
    check_eq("w1_pwrite",  64'(bus_if.PWRITE),    64'd1);
    check_eq("w1_pstrb",   64'(bus_if.PSTRB),     64'hF);
    check_eq("w1_pwdata",  64'(bus_if.PWDATA),    64'hDEADBEEF);
    check_eq("w1_pprot",   64'(bus_if.PPROT),     64'b011);
    check_eq("w1_setup_hr",64'(bus_if.HREADYOUT), 64'd0);
    tick();
    check_eq("w1_acc_pen", 64'(bus_if.PENABLE),   64'd1);
    check_eq("w1_acc_psel",64'(bus_if.PSEL),      64'd1);
    check_eq("w1_acc_addr",64'(bus_if.PADDR),     64'h104);
    check_eq("w1_acc_hr",  64'(bus_if.HREADYOUT), 64'd0);
    tick();
    check_eq("w1_resp_hr", 64'(bus_if.HREADYOUT), 64'd1);
    check_eq("w1_resp_err",64'(bus_if.HRESP),     64'd0);
    check_eq("w1_resp_psel",64'(bus_if.PSEL),     64'd0);
    check_eq("w1_hold_addr",64'(bus_if.PADDR),    64'h104);
    tick();

    // Read 0x020 with two wait states
    bus_if.PREADY = 1'b0;
    addr_phase(32'h020, 1'b0, HSIZE_WORD, 4'b0000);
    tick();
    bus_idle();
    check_eq("r1_pstrb",  64'(bus_if.PSTRB),  64'h0);
    check_eq("r1_pwrite", 64'(bus_if.PWRITE), 64'd0);
    check_eq("r1_paddr",  64'(bus_if.PADDR),  64'h020);
    check_eq("r1_pprot",  64'(bus_if.PPROT),  64'b110);
    tick();
    check_eq("r1_acc1", 64'({bus_if.PSEL, bus_if.PENABLE, bus_if.HREADYOUT}), 64'b110);
    tick();
    check_eq("r1_acc2", 64'({bus_if.PSEL, bus_if.PENABLE, bus_if.HREADYOUT}), 64'b110);
    tick();
    check_eq("r1_acc3", 64'({bus_if.PSEL, bus_if.PENABLE, bus_if.HREADYOUT}), 64'b110);
    bus_if.PREADY = 1'b1;
    bus_if.PRDATA = 32'h12345678;
    tick();
    bus_if.PRDATA = 32'hFFFF0000;
    check_eq("r1_hrdata", 64'(bus_if.HRDATA),    64'h12345678);
    check_eq("r1_resp_hr",64'(bus_if.HREADYOUT), 64'd1);
    tick();

    // Strobe generation for sub-word writes
    do_write("wb3", 32'h003, HSIZE_BYTE,  32'h000000AA, 4'b1000);
    do_write("wb0", 32'h000, HSIZE_BYTE,  32'h000000BB, 4'b0001);
    do_write("wh2", 32'h002, HSIZE_HWORD, 32'h0000CCCC, 4'b1100);
    do_write("wh1", 32'h001, HSIZE_HWORD, 32'h0000DDDD, 4'b0011);
    check_eq("hrdata_hold", 64'(bus_if.HRDATA), 64'h12345678);

    // No action for BUSY or deselected transfers
    addr_phase(32'h040, 1'b1, HSIZE_WORD, 4'b0000);
    bus_if.HTRANS = HTRANS_BUSY;
    tick();
    check_eq("busy_psel", 64'({bus_if.PSEL, bus_if.HREADYOUT, bus_if.HRESP}), 64'b010);
    bus_if.HTRANS = HTRANS_NONSEQ;
    bus_if.HSEL   = 1'b0;
    tick();
    check_eq("nosel_psel", 64'({bus_if.PSEL, bus_if.HREADYOUT, bus_if.HRESP}), 64'b010);
    bus_idle();

    // PSLVERR in ACCESS
    addr_phase(32'h080, 1'b1, HSIZE_WORD, 4'b0000);
    tick();
    bus_idle();
    bus_if.PSLVERR = 1'b1;
    tick();
    check_eq("se_acc", 64'({bus_if.PSEL, bus_if.PENABLE}), 64'b11);
    tick();
    bus_if.PSLVERR = 1'b0;
    check_eq("se_err1", 64'({bus_if.HREADYOUT, bus_if.HRESP, bus_if.PSEL}), 64'b010);
    tick();
    check_eq("se_err2", 64'({bus_if.HREADYOUT, bus_if.HRESP, bus_if.PSEL}), 64'b110);
    tick();
    check_eq("se_idle", 64'({bus_if.HREADYOUT, bus_if.HRESP, bus_if.PSEL}), 64'b100);

    // Oversized HSIZE
    addr_phase(32'h0C0, 1'b1, HSIZE_DWORD, 4'b0000);
    tick();
    bus_idle();
    check_eq("sz_err1", 64'({bus_if.HREADYOUT, bus_if.HRESP, bus_if.PSEL}), 64'b010);
    tick();
    check_eq("sz_err2", 64'({bus_if.HREADYOUT, bus_if.HRESP, bus_if.PSEL}), 64'b110);
    tick();
    check_eq("sz_idle", 64'({bus_if.HREADYOUT, bus_if.HRESP, bus_if.PSEL}), 64'b100);

    // Back-to-back: write, write, read with new NONSEQ in each RESP cycle
    addr_phase(32'h010, 1'b1, HSIZE_WORD, 4'b0010);
    tick();
    bus_idle();
    bus_if.HWDATA = 32'h11111111;
    check_eq("bb1_setup", 64'({bus_if.PSEL, bus_if.PENABLE, bus_if.PPROT}), 64'b10111);
    tick();
    tick();
    check_eq("bb1_resp_hr", 64'(bus_if.HREADYOUT), 64'd1);
    addr_phase(32'h014, 1'b1, HSIZE_WORD, 4'b0010);
    tick();
    bus_idle();
    bus_if.HWDATA = 32'h22222222;
    check_eq("bb2_setup_hr", 64'(bus_if.HREADYOUT), 64'd0);
    check_eq("bb2_setup",    64'({bus_if.PSEL, bus_if.PENABLE}), 64'b10);
    check_eq("bb2_paddr",    64'(bus_if.PADDR),  64'h014);
    check_eq("bb2_pwdata",   64'(bus_if.PWDATA), 64'h22222222);
    tick();
    tick();
    check_eq("bb2_resp_hr", 64'(bus_if.HREADYOUT), 64'd1);
    addr_phase(32'h018, 1'b0, HSIZE_WORD, 4'b0000);
    tick();
    bus_idle();
    check_eq("bb3_setup", 64'({bus_if.PSEL, bus_if.PENABLE, bus_if.HREADYOUT, bus_if.PWRITE}), 64'b1000);
    check_eq("bb3_paddr", 64'(bus_if.PADDR), 64'h018);
    bus_if.PRDATA = 32'hCAFEF00D;
    tick();
    tick();
    check_eq("bb3_hrdata", 64'(bus_if.HRDATA), 64'hCAFEF00D);
    tick();

    // Asynchronous reset during ACCESS
    bus_if.PREADY = 1'b0;
    addr_phase(32'h1FC, 1'b1, HSIZE_WORD, 4'b0000);
    tick();
    bus_idle();
    tick();
    check_eq("ar_acc", 64'({bus_if.PSEL, bus_if.PENABLE, bus_if.HREADYOUT}), 64'b110);
    #2;
    PRESETn = 1'b0;
    #1;
    check_eq("ar_now",    64'({bus_if.PSEL, bus_if.PENABLE, bus_if.HREADYOUT}), 64'b001);
    check_eq("ar_regs",   64'({bus_if.PADDR, bus_if.PWRITE, bus_if.PSTRB}), 64'd0);
    check_eq("ar_hrdata", 64'(bus_if.HRDATA), 64'd0);
    bus_if.PREADY = 1'b1;
    tick();
    PRESETn = 1'b1;
    tick();
    check_eq("ar_after", 64'({bus_if.PSEL, bus_if.HREADYOUT, bus_if.HRESP}), 64'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
